// File: rtl/issue_scheduler.sv
// Decode-stage issue controller: pending-write scoreboard, hazard/back-pressure stalls,
// branch-flush squash and a drain handshake for halt/IO.
module issue_scheduler #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [4:0]         src1_no,
  input  logic               src1_f,
  input  logic               src1_use,
  input  logic [4:0]         src2_no,
  input  logic               src2_f,
  input  logic               src2_use,
  input  logic [4:0]         dst_no,
  input  logic               dst_f,
  input  logic               dst_we,
  input  logic               ex_busy,
  input  logic               wb_valid,
  input  logic [4:0]         wb_no,
  input  logic               wb_f,
  input  logic               flush,
  input  logic               drain_req,
  output logic               dec_enable,
  output logic               if_stall,
  output logic               issue_valid,
  output logic               drain_done,
  output logic [1:0]         state,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic               iv_q, iv_d;
  logic [5:0]         last_dst_q;
  logic               last_we_q;
  logic [STALL_W-1:0] stall_q;

  logic [5:0] src1_idx, src2_idx, dst_idx, wb_idx;
  logic       hazard, stall_inc;

  assign src1_idx = {src1_f, src1_no};
  assign src2_idx = {src2_f, src2_no};
  assign dst_idx  = {dst_f, dst_no};
  assign wb_idx   = {wb_f, wb_no};

  // Integer r0 is never set in the scoreboard, so it can never raise a hazard.
  assign hazard = (src1_use & pend_q[src1_idx]) | (src2_use & pend_q[src2_idx]) |
                  (dst_we & pend_q[dst_idx]);

  assign dec_enable   = (state_q == StRun) & if_valid & ~hazard & ~ex_busy & ~flush;
  assign if_stall     = if_valid & ~dec_enable;
  assign issue_valid  = iv_q;
  assign drain_done   = (state_q == StDrain) & (pend_q == 64'd0) & ~iv_q;
  assign state        = state_q;
  assign stall_cycles = stall_q;
  assign stall_inc    = (state_q == StRun) & if_valid & ~dec_enable & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (flush) begin
          state_d = StFlush;
          cnt_d   = FlushLoad;
        end else if (drain_req) begin
          state_d = StDrain;
        end
      end
      StFlush: begin
        if (flush)               cnt_d   = FlushLoad;
        else if (cnt_q == 4'd0)  state_d = drain_req ? StDrain : StRun;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      StDrain: if (!drain_req && !flush) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if (flush)           iv_d = 1'b0;
    else if (dec_enable) iv_d = 1'b1;
    else if (ex_busy)    iv_d = iv_q;
    else                 iv_d = 1'b0;
  end

  // Ordering gives set priority over a same-cycle writeback clear.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid) pend_d[wb_idx] = 1'b0;
    if (flush && iv_q && last_we_q) pend_d[last_dst_q] = 1'b0;
    if (dec_enable && dst_we && (dst_idx != 6'd0)) pend_d[dst_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      pend_q     <= 64'd0;
      iv_q       <= 1'b0;
      last_dst_q <= 6'd0;
      last_we_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      iv_q    <= iv_d;
      if (dec_enable) begin
        last_dst_q <= dst_idx;
        last_we_q  <= dst_we;
      end
      if (stall_inc && (stall_q != {STALL_W{1'b1}})) begin
        stall_q <= stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed table-driven bench for issue_scheduler; a second instance with a narrow
// stall counter shadows the same stimulus to exercise saturation.
module tb_issue_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic if_valid, src1_f, src1_use, src2_f, src2_use, dst_f, dst_we;
  logic [4:0] src1_no, src2_no, dst_no, wb_no;
  logic ex_busy, wb_valid, wb_f, flush, drain_req;
  logic dec_enable, if_stall, issue_valid, drain_done;
  logic [1:0] state;
  logic [15:0] stall_cycles;
  logic s_dec, s_ifs, s_iv, s_dd;
  logic [1:0] s_state;
  logic [2:0] s_stall;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scheduler #(.FLUSH_CYCLES(2), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .src1_no(src1_no), .src1_f(src1_f), .src1_use(src1_use),
    .src2_no(src2_no), .src2_f(src2_f), .src2_use(src2_use),
    .dst_no(dst_no), .dst_f(dst_f), .dst_we(dst_we),
    .ex_busy(ex_busy), .wb_valid(wb_valid), .wb_no(wb_no), .wb_f(wb_f),
    .flush(flush), .drain_req(drain_req),
    .dec_enable(dec_enable), .if_stall(if_stall), .issue_valid(issue_valid),
    .drain_done(drain_done), .state(state), .stall_cycles(stall_cycles)
  );

  issue_scheduler #(.FLUSH_CYCLES(2), .STALL_W(3)) dut_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid),
    .src1_no(src1_no), .src1_f(src1_f), .src1_use(src1_use),
    .src2_no(src2_no), .src2_f(src2_f), .src2_use(src2_use),
    .dst_no(dst_no), .dst_f(dst_f), .dst_we(dst_we),
    .ex_busy(ex_busy), .wb_valid(wb_valid), .wb_no(wb_no), .wb_f(wb_f),
    .flush(flush), .drain_req(drain_req),
    .dec_enable(s_dec), .if_stall(s_ifs), .issue_valid(s_iv),
    .drain_done(s_dd), .state(s_state), .stall_cycles(s_stall)
  );

  typedef struct {
    logic       iv;
    logic [5:0] s1;
    logic       s1u;
    logic [5:0] s2;
    logic       s2u;
    logic [5:0] d;
    logic       dwe;
    logic       busy;
    logic       wbv;
    logic [5:0] wb;
    logic       fl;
    logic       dr;
    logic       e_dec;
    logic       e_iv;
    logic [1:0] e_st;
    logic       e_dd;
    int         e_stall;
  } vec_t;

  localparam int NV = 49;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic iv, input logic [5:0] s1, input logic s1u,
                              input logic [5:0] s2, input logic s2u, input logic [5:0] d,
                              input logic dwe, input logic busy, input logic wbv,
                              input logic [5:0] wb, input logic fl, input logic dr,
                              input logic e_dec, input logic e_iv, input logic [1:0] e_st,
                              input logic e_dd, input int e_stall);
    vec_t v;
    v.iv = iv; v.s1 = s1; v.s1u = s1u; v.s2 = s2; v.s2u = s2u; v.d = d; v.dwe = dwe;
    v.busy = busy; v.wbv = wbv; v.wb = wb; v.fl = fl; v.dr = dr;
    v.e_dec = e_dec; v.e_iv = e_iv; v.e_st = e_st; v.e_dd = e_dd; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_valid = v.iv;
    {src1_f, src1_no} = v.s1; src1_use = v.s1u;
    {src2_f, src2_no} = v.s2; src2_use = v.s2u;
    {dst_f, dst_no} = v.d; dst_we = v.dwe;
    ex_busy = v.busy; wb_valid = v.wbv; {wb_f, wb_no} = v.wb;
    flush = v.fl; drain_req = v.dr;
  endtask

  // Inputs settle 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic run_vec(input int i);
    vec_t v;
    int sat;
    v = tbl[i];
    sat = (v.e_stall > 7) ? 7 : v.e_stall;
    drive(v);
    #3;
    chk($sformatf("v%0d dec_enable", i), 32'(dec_enable), 32'(v.e_dec));
    chk($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(v.iv & ~v.e_dec));
    chk($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(v.e_iv));
    chk($sformatf("v%0d state", i), 32'(state), 32'(v.e_st));
    chk($sformatf("v%0d drain_done", i), 32'(drain_done), 32'(v.e_dd));
    chk($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), v.e_stall);
    chk($sformatf("v%0d sat_stall", i), 32'(s_stall), sat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            iv s1 u  s2 u  d  we by wv wb fl dr  dec iv st dd stall
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 1, 0, 1);
    tbl[4]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 2);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 2);
    tbl[6]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 2);
    tbl[7]  = mk(1, 0, 0, 0, 0, 32, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2);
    tbl[8]  = mk(1, 0, 0, 32, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2);
    tbl[9]  = mk(1, 0, 0, 32, 1, 0, 0, 0, 1, 32, 0, 0, 0, 0, 1, 0, 3);
    tbl[10] = mk(1, 0, 0, 32, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);
    tbl[11] = mk(1, 0, 0, 0, 0, 35, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0,  0, 1, 1, 0, 4);
    tbl[13] = mk(1, 35, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 4);
    tbl[14] = mk(1, 35, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 4);
    tbl[15] = mk(1, 35, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 4);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 5);
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 6);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 7);
    tbl[20] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 7);
    tbl[21] = mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 7);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0, 7);
    tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,  0, 0, 3, 0, 7);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1,  0, 0, 3, 0, 7);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 1, 7);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 7);
    tbl[27] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 7);
    // busy stalls past the 3-bit counter's ceiling
    tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 7);
    tbl[29] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 8);
    tbl[30] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 9);
    tbl[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 10);
    // back-to-back flush reloads the counter
    tbl[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 10);
    tbl[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 0, 10);
    tbl[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 10);
    tbl[35] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 10);
    tbl[36] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 10);
    // flush while draining squashes the held writer and stays in DRAIN
    tbl[37] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 10);
    tbl[38] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 10);
    tbl[39] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1,  0, 1, 3, 0, 10);
    tbl[40] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3, 1, 10);
    tbl[41] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 10);
    tbl[42] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 10);
    tbl[43] = mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 10);
    // after mid-operation reset: r10 no longer pending; set beats same-cycle wb on r11
    tbl[44] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[45] = mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 11, 0, 0, 1, 0, 1, 0, 0);
    tbl[46] = mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tbl[47] = mk(1, 11, 1, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0, 1, 0, 1);
    tbl[48] = mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2);

    rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #4;
    chk("reset state", 32'(state), 0);
    chk("reset issue_valid", 32'(issue_valid), 0);
    chk("reset dec_enable", 32'(dec_enable), 0);
    chk("reset if_stall", 32'(if_stall), 0);
    chk("reset drain_done", 32'(drain_done), 0);
    chk("reset stall_cycles", 32'(stall_cycles), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 44; i++) run_vec(i);

    // Asynchronous reset asserted mid-cycle with r10 in flight.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("pre-reset issue_valid", 32'(issue_valid), 1);
    rst = 1'b1;
    #1;
    chk("async reset state", 32'(state), 0);
    chk("async reset issue_valid", 32'(issue_valid), 0);
    chk("async reset stall_cycles", 32'(stall_cycles), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 44; i < NV; i++) run_vec(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Controller for the decode stage: generates the decode stage's enable and tracks which decoded instruction is valid.
- Keeps a 64-entry pending-write scoreboard: 32 integer and 32 float registers.
- Stalls decode on RAW/WAW hazards and execute back-pressure; squashes on branch flush; supports a drain handshake for halt/IO.
- Sits between fetch, the decode stage, execute and writeback.

Parameters:
- FLUSH_CYCLES, 2: cycles decode stays disabled after a flush (legal range 1..15).
- STALL_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  single system clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  fetch presents a valid command this cycle
- src1_no  in  5  first source register number
- src1_f  in  1  first source is float
- src1_use  in  1  instruction reads the first source
- src2_no, src2_f, src2_use  in  5/1/1  second source, same meaning
- dst_no  in  5  destination register number
- dst_f  in  1  destination is float
- dst_we  in  1  instruction writes the destination
- ex_busy  in  1  execute cannot accept the decoded instruction this cycle
- wb_valid  in  1  writeback retires a register write
- wb_no  in  5  writeback register number
- wb_f  in  1  writeback register is float
- flush  in  1  branch redirect; squash decode
- drain_req  in  1  request to quiesce the pipeline
- dec_enable  out  1  enable to the decode stage (combinational)
- if_stall  out  1  hold fetch PC; equals if_valid & ~dec_enable
- issue_valid  out  1  decode output registers hold a live instruction
- drain_done  out  1  pipeline empty while draining
- state  out  2  FSM state
- stall_cycles  out  STALL_W  saturating count of hazard or busy stalls

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; scoreboard=0; issue_valid=0; last_dst=0; last_we=0; flush counter=0; stall_cycles=0.
  - Combinational outputs evaluate to 0.
- FSM states: IDLE=0, RUN=1, FLUSH=2, DRAIN=3.
  - IDLE: goes to RUN after 1 cycle unconditionally.
  - RUN, flush=1: go to FLUSH; counter loads FLUSH_CYCLES-1.
  - RUN, drain_req=1 and flush=0: go to DRAIN.
  - FLUSH, counter==0: go to DRAIN if drain_req=1, else RUN. Otherwise decrement.
  - FLUSH, flush=1 again: reload the counter.
  - DRAIN, drain_req=0: go to RUN. A flush in DRAIN squashes but stays in DRAIN.
- Scoreboard key is {f, no}. Integer r0 is never marked pending and never causes a hazard; float f0 is an ordinary register.
- hazard = (src1_use & pend[src1]) | (src2_use & pend[src2]) | (dst_we & pend[dst]).
  - No same-cycle writeback bypass: a bit cleared by wb at edge N stops stalling from cycle N+1.
- dec_enable = (state==RUN) & if_valid & ~hazard & ~ex_busy & ~flush.
- issue_valid next value, first match wins:
  - flush: 0
  - dec_enable: 1
  - ex_busy: hold current value
  - otherwise: 0
  - Execute consumes when issue_valid & ~ex_busy.
- Scoreboard update per edge:
  - Clear pend[wb] when wb_valid.
  - Set pend[dst] when dec_enable & dst_we (excluding int r0).
  - Set and clear of the same register in one cycle: set wins.
  - On dec_enable, record last_dst={dst_f,dst_no} and last_we.
- Flush squash: if flush & issue_valid & last_we, clear pend[last_dst]. WAW stalling guarantees no older writer owns that bit.
- drain_done = (state==DRAIN) & (scoreboard==0) & ~issue_valid.
- stall_cycles increments when state==RUN & if_valid & ~dec_enable & ~flush. It saturates at all-ones.
- Reset mid-operation: all state returns immediately to reset values, including scoreboard bits of in-flight instructions.

Test Plan:
- Release reset with if_valid=1 and no hazards -> IDLE for 1 cycle, then dec_enable=1 every cycle; issue_valid=1 from the following edge.
- Issue dst int r5 (dst_we); next instruction has src1=int r5 -> dec_enable=0 and stall_cycles counts up. wb_valid r5 at edge N -> dec_enable=1 in cycle N+1.
- Issue writing int r0, then read r0; and issue writing f0, then read f0 -> no stall on r0; stall on f0 until its writeback.
- Issue dst f3, then flush next cycle with ex_busy=1 -> issue_valid=0, pend[f3] cleared, dec_enable=0 for FLUSH_CYCLES (2) cycles, then RUN.
- ex_busy=1 for 3 cycles with issue_valid=1 -> issue_valid held at 1, dec_enable=0, if_stall=1. After release, 1 consume then resume.
- drain_req=1 with two writes pending -> state=3, dec_enable=0, drain_done=0 until both wb retire, then 1. Drop drain_req -> RUN next cycle.
